// File: rtl/coeff_fifo_arbiter.sv
// Round-robin arbiter that shares one coefficient FIFO between two producers.
// The FIFO exposes no full flag, so this block tracks occupancy from its own
// writes and the consumer's pops, and back-pressures the granted producer.
module coeff_fifo_arbiter #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned BURST  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_valid,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_valid,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [DATA_W-1:0] fifo_in,
    output logic              fifo_in_valid,
    input  logic              fifo_pop,
    output logic [4:0]        level,
    output logic [1:0]        grant
);

    localparam int unsigned BcntW = (BURST > 1) ? $clog2(BURST) : 1;
    // Equal FIFO pointers mean empty, so one storage entry is never usable.
    localparam logic [4:0]       LevelMax = 5'(DEPTH - 1);
    localparam logic [BcntW-1:0] BcntMax  = BcntW'(BURST - 1);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StG0   = 2'b01,
        StG1   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    logic [4:0]       level_q, level_d;

    logic space;
    logic beat0, beat1, beat;
    logic pop_eff;

    // Handshake and write-port datapath, from registered state only.
    always_comb begin
        space         = level_q < LevelMax;
        req0_ready    = (state_q == StG0) && space;
        req1_ready    = (state_q == StG1) && space;
        beat0         = req0_valid && req0_ready;
        beat1         = req1_valid && req1_ready;
        beat          = beat0 || beat1;
        fifo_in_valid = beat;
        fifo_in       = (state_q == StG1) ? req1_data : req0_data;
        grant         = state_q;
        level         = level_q;
    end

    // Next-state, priority pointer and burst counter.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && (!req1_valid || !prio_q)) begin
                    state_d = StG0;
                    prio_d  = 1'b1;
                    bcnt_d  = '0;
                end else if (req1_valid) begin
                    state_d = StG1;
                    prio_d  = 1'b0;
                    bcnt_d  = '0;
                end
            end
            StG0: begin
                if (beat0) bcnt_d = bcnt_q + BcntW'(1);
                // A grant stalled only by a full FIFO is held.
                if (!req0_valid || (beat0 && (req0_last || bcnt_q == BcntMax))) begin
                    state_d = StIdle;
                end
            end
            StG1: begin
                if (beat1) bcnt_d = bcnt_q + BcntW'(1);
                if (!req1_valid || (beat1 && (req1_last || bcnt_q == BcntMax))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Occupancy: a pop on an empty FIFO is ignored.
    always_comb begin
        pop_eff = fifo_pop && (level_q != 5'd0);
        level_d = level_q + {4'd0, beat} - {4'd0, pop_eff};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            bcnt_q  <= '0;
            level_q <= 5'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            bcnt_q  <= bcnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_coeff_fifo_arbiter.sv
// Directed bench for coeff_fifo_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 4 units after the edge.
module tb_coeff_fifo_arbiter;

    logic        clk;
    logic        resetn;
    logic [12:0] req0_data, req1_data;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [12:0] fifo_in;
    logic        fifo_in_valid;
    logic        fifo_pop;
    logic [4:0]  level;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    coeff_fifo_arbiter #(
        .DATA_W(13),
        .DEPTH (16),
        .BURST (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req0_data    (req0_data),
        .req0_valid   (req0_valid),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_data    (req1_data),
        .req1_valid   (req1_valid),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .fifo_in      (fifo_in),
        .fifo_in_valid(fifo_in_valid),
        .fifo_pop     (fifo_pop),
        .level        (level),
        .grant        (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  pat;
        logic [12:0] d;
        logic        b;
        int          writes;
        logic [1:0]  eg;

        resetn     = 1'b0;
        req0_data  = '0;
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        req1_data  = '0;
        req1_valid = 1'b0;
        req1_last  = 1'b0;
        fifo_pop   = 1'b0;

        // Reset state.
        tick();
        tick();
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_wr", 32'(fifo_in_valid), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Single requester: 6 beats, last on beat 6. Beats on cycles 1-4, 6-7.
        pat        = 8'b1101_1110;
        d          = 13'd1;
        req0_data  = d;
        req0_last  = 1'b0;
        req0_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #3;
            b = fifo_in_valid;
            chk($sformatf("single_wr%0d", c), 32'(fifo_in_valid), 32'(pat[c]));
            chk($sformatf("single_gnt%0d", c), 32'(grant), {31'd0, pat[c]});
            if (b) chk($sformatf("single_data%0d", c), 32'(fifo_in), 32'(d));
            tick();
            if (b) begin
                d         = d + 13'd1;
                req0_data = d;
                req0_last = (d == 13'd6);
                if (d == 13'd7) req0_valid = 1'b0;
            end
        end
        #3;
        chk("single_level", 32'(level), 32'd6);
        chk("single_release", 32'(grant), 32'd0);

        // One-beat transfer brings level to 7, then beat with pop holds it at 7.
        req0_data  = 13'd7;
        req0_last  = 1'b1;
        req0_valid = 1'b1;
        tick();
        #3;
        chk("bp_wr_a", 32'(fifo_in_valid), 32'd1);
        chk("bp_data_a", 32'(fifo_in), 32'h7);
        tick();
        #3;
        chk("bp_level7", 32'(level), 32'd7);
        chk("bp_idle", 32'(grant), 32'd0);
        req0_data = 13'd8;
        tick();
        fifo_pop = 1'b1;
        #3;
        chk("bp_wr_b", 32'(fifo_in_valid), 32'd1);
        tick();
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        fifo_pop   = 1'b0;
        #3;
        chk("bp_level_hold", 32'(level), 32'd7);
        fifo_pop = 1'b1;
        repeat (3) tick();
        #3;
        chk("pop_level4", 32'(level), 32'd4);
        // Nine pops total against seven entries: extra pops at zero are ignored.
        repeat (6) tick();
        #3;
        chk("pop_empty", 32'(level), 32'd0);
        fifo_pop = 1'b0;

        // Full: requester 1 streams, no pops; exactly 15 writes, grant held.
        d          = 13'd1;
        req1_data  = d;
        req1_valid = 1'b1;
        writes     = 0;
        for (int c = 0; c < 25; c++) begin
            #3;
            b = fifo_in_valid;
            if (b) begin
                writes++;
                chk($sformatf("full_data%0d", c), 32'(fifo_in), 32'(d));
            end
            tick();
            if (b) begin
                d         = d + 13'd1;
                req1_data = d;
            end
        end
        #3;
        chk("full_writes", 32'(writes), 32'd15);
        chk("full_level", 32'(level), 32'd15);
        chk("full_rdy1", 32'(req1_ready), 32'd0);
        chk("full_held", 32'(grant), 32'd2);
        fifo_pop = 1'b1;
        #1;
        chk("full_pop_same_cycle", 32'(req1_ready), 32'd0);
        tick();
        fifo_pop = 1'b0;
        #3;
        chk("full_level14", 32'(level), 32'd14);
        chk("full_rdy_again", 32'(req1_ready), 32'd1);
        chk("full_beat16", 32'(fifo_in), 32'd16);
        tick();
        req1_valid = 1'b0;
        #3;
        chk("full_level15b", 32'(level), 32'd15);
        chk("full_release", 32'(grant), 32'd0);

        // Drain, then reset after two beats of requester 0.
        fifo_pop = 1'b1;
        repeat (16) tick();
        fifo_pop   = 1'b0;
        req0_data  = 13'h0aa;
        req0_last  = 1'b0;
        req0_valid = 1'b1;
        tick();
        tick();
        tick();
        #3;
        chk("mid_level2", 32'(level), 32'd2);
        resetn     = 1'b0;
        req1_data  = 13'h155;
        req1_valid = 1'b1;
        tick();
        #3;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_rdy0", 32'(req0_ready), 32'd0);
        chk("mid_rst_rdy1", 32'(req1_ready), 32'd0);
        resetn   = 1'b1;
        fifo_pop = 1'b1;
        tick();

        // Contention with pops every cycle: 01 x4, gap, 10 x4, gap, repeating.
        for (int c = 0; c < 20; c++) begin
            #3;
            if ((c % 10) < 4) eg = 2'b01;
            else if ((c % 10) == 4 || (c % 10) == 9) eg = 2'b00;
            else eg = 2'b10;
            chk($sformatf("cont_gnt%0d", c), 32'(grant), 32'(eg));
            chk($sformatf("cont_wr%0d", c), 32'(fifo_in_valid), 32'(eg != 2'b00));
            if (eg == 2'b01) chk($sformatf("cont_d%0d", c), 32'(fifo_in), 32'h0aa);
            if (eg == 2'b10) chk($sformatf("cont_d%0d", c), 32'(fifo_in), 32'h155);
            tick();
        end
        #3;
        chk("cont_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
